// File: rtl/spi_pkg.sv
`default_nettype none
// ==========================================================================
// spi_pkg - state encoding and elaboration helpers for spi_slave_word
// Revision: 1.0
// ==========================================================================
package spi_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  // Sampling happens on the rising SCK edge when CPOL and CPHA agree.
  function automatic bit sample_rising(input int cpol, input int cpha);
    return (cpol != 0) == (cpha != 0);
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ==========================================================================
// spi_sync_edge - N-stage synchronizer with level and rise/fall strobes
// Revision: 1.0
// ==========================================================================
module spi_sync_edge #(
  parameter int STAGES = 3,
  parameter bit IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] taps;

  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= {STAGES{IDLE}};
    end else begin
      taps <= {taps[STAGES-2:0], din};
    end
  end

  // Edges compare the two oldest taps; level is the newer of the pair.
  assign level = taps[STAGES-2];
  assign rise  = taps[STAGES-2] & ~taps[STAGES-1];
  assign fall  = ~taps[STAGES-2] & taps[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_word.sv
`default_nettype none
// ==========================================================================
// spi_slave_word - full-duplex SPI slave, configurable width/order/mode.
// Optional SPI_SLAVE_ERR_EN adds frame_err/overrun/underrun and rx_hold_n.
// Revision: 1.0
// ==========================================================================
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ssel,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy
`ifdef SPI_SLAVE_ERR_EN
  ,
  input  logic             rx_hold_n,
  output logic             frame_err,
  output logic             overrun,
  output logic             underrun
`endif
);

  localparam int               CNT_W       = clog2(WIDTH);
  localparam bit               SAMPLE_RISE = sample_rising(CPOL, CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);

  logic unused_sck_level;
  logic unused_ssel_rise;
  logic sck_rise;
  logic sck_fall;
  logic ssel_level;
  logic ssel_fall;
  logic [1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(3), .IDLE(CPOL != 0)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sck),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(3), .IDLE(1'b1)) u_ssel_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ssel),
    .level (ssel_level),
    .rise  (unused_ssel_rise),
    .fall  (ssel_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= 2'b00;
    end else begin
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end
  assign mosi_s = mosi_sync[1];

  spi_state_t       state;
  logic [CNT_W-1:0] bitcnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             load_pending;
  logic             skip_shift;
  logic             selected;
  logic             sample_edge;
  logic             shift_edge;
  logic             load;
  logic             write;

  assign selected    = ~ssel_level;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign write       = tx_valid & ~hold_full;
  assign load        = (state == ST_IDLE && ssel_fall) ||
                       (state == ST_SHIFT && selected && shift_edge && load_pending);

  assign tx_ready = ~hold_full;
  assign busy     = (state == ST_SHIFT);
  assign miso_oe  = selected;

  // rx_next is the word including the bit arriving now; only WIDTH-1 bits
  // of history are needed because the final bit goes straight to rx_data.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign rx_next    = {rx_shift, mosi_s};
      assign tx_shifted = {tx_shift[WIDTH-2:0], 1'b0};
      assign miso       = tx_shift[WIDTH-1];
    end else begin : g_lsb_first
      assign rx_next    = {mosi_s, rx_shift};
      assign tx_shifted = {1'b0, tx_shift[WIDTH-1:1]};
      assign miso       = tx_shift[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bitcnt       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_shift     <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      load_pending <= 1'b0;
      skip_shift   <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      underrun     <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= load & ~hold_full;
`endif
      // A write in the same cycle as a load lands in hold after the load
      // has taken the old contents.
      if (write) begin
        hold <= tx_data;
      end
      hold_full <= (hold_full & ~load) | write;
      if (load) begin
        tx_shift <= hold_full ? hold : '0;
      end

      case (state)
        ST_IDLE: begin
          if (ssel_fall) begin
            state        <= ST_SHIFT;
            bitcnt       <= '0;
            load_pending <= 1'b0;
            skip_shift   <= (CPHA != 0);
          end
        end
        ST_SHIFT: begin
          if (!selected) begin
            state        <= ST_IDLE;
            bitcnt       <= '0;
            load_pending <= 1'b0;
            skip_shift   <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            frame_err    <= (bitcnt != '0);
`endif
          end else begin
            if (sample_edge) begin
              if (MSB_FIRST != 0) begin
                rx_shift <= rx_next[WIDTH-2:0];
              end else begin
                rx_shift <= rx_next[WIDTH-1:1];
              end
              if (bitcnt == LAST_BIT) begin
                bitcnt       <= '0;
                rx_data      <= rx_next;
                rx_valid     <= 1'b1;
                load_pending <= 1'b1;
`ifdef SPI_SLAVE_ERR_EN
                overrun      <= ~rx_hold_n;
`endif
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end
            if (shift_edge) begin
              if (load_pending) begin
                load_pending <= 1'b0;
              end else if (skip_shift) begin
                skip_shift <= 1'b0;
              end else begin
                tx_shift <= tx_shifted;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_word.sv
`default_nettype none
// ==========================================================================
// tb_spi_slave_word - randomized SPI master driving five slave configurations
// Revision: 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_spi_slave_word;

  localparam int NI = 5;
  localparam int HP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sck_a[NI];
  logic        ssel_a[NI];
  logic        mosi_a[NI];
  logic        tx_valid_a[NI];
  logic [15:0] tx_data_a[NI];
  logic        miso_a[NI];
  logic        miso_oe_a[NI];
  logic        rx_valid_a[NI];
  logic        tx_ready_a[NI];
  logic        busy_a[NI];
  logic [15:0] rx_data_a[NI];
  logic        hold_n = 1'b1;
`ifdef SPI_SLAVE_ERR_EN
  logic        ferr_a[NI];
  logic        orun_a[NI];
  logic        urun_a[NI];
`endif

  function automatic int w_of(input int i);
    case (i)
      0:       return 8;
      4:       return 5;
      default: return 16;
    endcase
  endfunction
  function automatic int cpol_of(input int i);
    return (i == 2 || i == 3) ? 1 : 0;
  endfunction
  function automatic int cpha_of(input int i);
    return (i == 1 || i == 3 || i == 4) ? 1 : 0;
  endfunction
  function automatic int msb_of(input int i);
    return (i == 4) ? 0 : 1;
  endfunction
  function automatic logic [15:0] mask(input int w);
    return 16'((32'd1 << w) - 1);
  endfunction

  generate
    for (genvar i = 0; i < NI; i++) begin : g_dut
      localparam int W = w_of(i);
      logic [W-1:0] rxd;
      spi_slave_word #(
        .WIDTH(W), .CPOL(cpol_of(i)), .CPHA(cpha_of(i)), .MSB_FIRST(msb_of(i))
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck_a[i]),
        .ssel     (ssel_a[i]),
        .mosi     (mosi_a[i]),
        .miso     (miso_a[i]),
        .miso_oe  (miso_oe_a[i]),
        .rx_data  (rxd),
        .rx_valid (rx_valid_a[i]),
        .tx_data  (tx_data_a[i][W-1:0]),
        .tx_valid (tx_valid_a[i]),
        .tx_ready (tx_ready_a[i]),
        .busy     (busy_a[i])
`ifdef SPI_SLAVE_ERR_EN
        ,
        .rx_hold_n(hold_n),
        .frame_err(ferr_a[i]),
        .overrun  (orun_a[i]),
        .underrun (urun_a[i])
`endif
      );
      assign rx_data_a[i] = 16'(rxd);
    end
  endgenerate

  // Reference model: per-instance holding register, expected rx words,
  // last completed word and expected error-pulse totals.
  int          checks = 0;
  int          failures = 0;
  int          act = -1;
  logic [15:0] exp_rx[$];
  bit          mfull[NI];
  logic [15:0] mval[NI];
  logic [15:0] last_rx[NI];
  logic [15:0] mosi_words[4];
  int          ferr_cnt = 0, urun_cnt = 0, orun_cnt = 0;
  int          exp_ferr = 0, exp_urun = 0, exp_orun = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rx_valid_a[k]) begin
        if (k == act && exp_rx.size() > 0) check("rx_data", rx_data_a[k], exp_rx.pop_front());
        else check("rx_valid_unexp", rx_valid_a[k], 1'b0);
      end
`ifdef SPI_SLAVE_ERR_EN
      if (ferr_a[k]) ferr_cnt++;
      if (urun_a[k]) urun_cnt++;
      if (orun_a[k]) orun_cnt++;
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Every word start takes the holding register, or zeros if it is empty.
  function automatic logic [15:0] model_load(input int i);
    logic [15:0] v;
    v = mfull[i] ? mval[i] : 16'h0;
    if (!mfull[i]) exp_urun++;
    mfull[i] = 1'b0;
    return v;
  endfunction

  task automatic write_hold(input int i, input logic [15:0] d);
    check("tx_ready", tx_ready_a[i], !mfull[i]);
    tx_data_a[i]  = d;
    tx_valid_a[i] = 1'b1;
    @(negedge clk);
    tx_valid_a[i] = 1'b0;
    if (!mfull[i]) begin
      mfull[i] = 1'b1;
      mval[i]  = d & mask(w_of(i));
    end
  endtask

  task automatic do_bit(input int i, input logic mb, output logic sb);
    logic idle;
    idle = (cpol_of(i) != 0);
    if (cpha_of(i) == 0) begin
      mosi_a[i] = mb;
      repeat (HP) @(negedge clk);
      sb = miso_a[i];
      sck_a[i] = ~idle;
      repeat (HP) @(negedge clk);
      sck_a[i] = idle;
    end else begin
      sck_a[i]  = ~idle;
      mosi_a[i] = mb;
      repeat (HP) @(negedge clk);
      sb = miso_a[i];
      sck_a[i] = idle;
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int i, input int nwords, input int abort_bits, input bit refill);
    int          w;
    int          nb;
    bit          aborted;
    logic [15:0] mw, got, exp_tx;
    logic        sb;
    w = w_of(i);
    nb = 0;
    aborted = 1'b0;
    act = i;
    ssel_a[i] = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_in_frame", busy_a[i], 1'b1);
    check("miso_oe_in_frame", miso_oe_a[i], 1'b1);
    for (int k = 0; k < nwords && !aborted; k++) begin
      mw = mosi_words[k] & mask(w);
      exp_tx = model_load(i);
      exp_rx.push_back(mw);
      got = '0;
      for (int b = 0; b < w; b++) begin
        if (abort_bits > 0 && nb == abort_bits) begin
          aborted = 1'b1;
          break;
        end
        do_bit(i, (msb_of(i) != 0) ? mw[w-1-b] : mw[b], sb);
        nb++;
        if (msb_of(i) != 0) got[w-1-b] = sb;
        else got[b] = sb;
        if (refill && b == 1) write_hold(i, 16'($urandom));
      end
      if (aborted) begin
        void'(exp_rx.pop_back());
        exp_ferr++;
      end else begin
        check("miso_word", got, exp_tx);
        last_rx[i] = mw;
        if (!hold_n) exp_orun++;
      end
    end
    // With CPHA=0 the trailing edge after the last completed word still loads.
    if (!aborted && cpha_of(i) == 0) void'(model_load(i));
    repeat (HP) @(negedge clk);
    ssel_a[i] = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_after", busy_a[i], 1'b0);
    check("miso_oe_after", miso_oe_a[i], 1'b0);
    check("tx_ready_after", tx_ready_a[i], !mfull[i]);
    check("rx_data_held", rx_data_a[i], last_rx[i]);
    check("rx_pending", exp_rx.size(), 0);
    exp_rx.delete();
`ifdef SPI_SLAVE_ERR_EN
    check("frame_err_cnt", ferr_cnt, exp_ferr);
    check("underrun_cnt", urun_cnt, exp_urun);
    check("overrun_cnt", orun_cnt, exp_orun);
`endif
  endtask

  initial begin
    int   i, nw, ab;
    logic dummy;
    for (int k = 0; k < NI; k++) begin
      sck_a[k]      = (cpol_of(k) != 0);
      ssel_a[k]     = 1'b1;
      mosi_a[k]     = 1'b0;
      tx_valid_a[k] = 1'b0;
      tx_data_a[k]  = '0;
      mfull[k]      = 1'b0;
      mval[k]       = '0;
      last_rx[k]    = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_rx_data", rx_data_a[k], 16'h0);
      check("rst_rx_valid", rx_valid_a[k], 1'b0);
      check("rst_miso", miso_a[k], 1'b0);
      check("rst_miso_oe", miso_oe_a[k], 1'b0);
      check("rst_busy", busy_a[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check("rst_tx_ready", tx_ready_a[k], 1'b1);

    // Mode 0, 8-bit: A5 out, 3C in.
    write_hold(0, 16'h00A5);
    mosi_words[0] = 16'h003C;
    run_frame(0, 1, 0, 1'b0);

    // Modes 1..3, 16-bit.
    for (int k = 1; k <= 3; k++) begin
      write_hold(k, 16'h1234);
      mosi_words[0] = 16'hBEEF;
      run_frame(k, 1, 0, 1'b0);
    end

    // Three back-to-back words with refill after each load.
    for (int k = 0; k < NI; k++) begin
      write_hold(k, 16'($urandom));
      for (int m = 0; m < 4; m++) mosi_words[m] = 16'($urandom);
      run_frame(k, 3, 0, 1'b1);
    end

    // Frame aborted after 5 bits, then a clean frame.
    for (int k = 0; k < 2; k++) begin
      if (!mfull[k]) write_hold(k, 16'($urandom));
      mosi_words[0] = 16'($urandom);
      run_frame(k, 1, 5, 1'b0);
      mosi_words[0] = 16'($urandom);
      run_frame(k, 1, 0, 1'b0);
    end

    // Empty holding register: zeros go out.
    if (mfull[2]) begin
      mosi_words[0] = 16'($urandom);
      run_frame(2, 1, 0, 1'b0);
    end
    mosi_words[0] = 16'($urandom);
    run_frame(2, 1, 0, 1'b0);

    // Reset after 3 bits of a frame.
    act = 0;
    if (!mfull[0]) write_hold(0, 16'($urandom));
    ssel_a[0] = 1'b0;
    repeat (6) @(negedge clk);
    void'(model_load(0));
    for (int b = 0; b < 3; b++) do_bit(0, b[0], dummy);
    rst = 1'b1;
    ssel_a[0] = 1'b1;
    sck_a[0]  = 1'b0;
    mosi_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_rx_data", rx_data_a[0], 16'h0);
    check("mid_rst_rx_valid", rx_valid_a[0], 1'b0);
    check("mid_rst_miso", miso_a[0], 1'b0);
    check("mid_rst_miso_oe", miso_oe_a[0], 1'b0);
    check("mid_rst_busy", busy_a[0], 1'b0);
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      mfull[k]   = 1'b0;
      last_rx[k] = '0;
    end
    @(negedge clk);
    check("mid_rst_tx_ready", tx_ready_a[0], 1'b1);
    write_hold(0, 16'($urandom));
    mosi_words[0] = 16'($urandom);
    run_frame(0, 1, 0, 1'b0);

    // Randomized frames across all configurations.
    for (int n = 0; n < 14; n++) begin
      i  = $urandom_range(0, NI - 1);
      nw = $urandom_range(1, 3);
      hold_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) write_hold(i, 16'($urandom));
      for (int m = 0; m < 4; m++) mosi_words[m] = 16'($urandom);
      ab = 0;
      if ($urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, nw * w_of(i) - 1);
        if (ab % w_of(i) == 0) ab = ab - 1;
      end
      run_frame(i, nw, ab, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
